// File: rtl/pe_pkg.sv
// Shared PE datapath widths, used by the PE array and by the post-processing block.
package pe_pkg;

  localparam int unsigned PE_N            = 16;
  localparam int unsigned PE_SUM_WIDTH    = 2 * PE_N + 4;
  localparam int unsigned PE_BIAS_GROWTH  = 1;
  localparam int unsigned PE_ROUND_GROWTH = 1;

  // Width of a sum after the bias has been added.
  function automatic int unsigned pe_acc_width(input int unsigned sum_w);
    return sum_w + PE_BIAS_GROWTH;
  endfunction

  // Width of a biased sum plus the rounding constant.
  function automatic int unsigned pe_rnd_width(input int unsigned sum_w);
    return sum_w + PE_BIAS_GROWTH + PE_ROUND_GROWTH;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is forced to zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is allowed when full.
    do_push = push && (!full || do_pop);

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    rdata = empty ? '0 : mem_q[rd_q];
    count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pe_post_proc.sv
// PE output post-processing: bias add, ReLU, rounding shift, saturation, 2:1 max-pool,
// frame tagging and a credit-protected output FIFO.
module pe_post_proc
  import pe_pkg::*;
#(
  parameter int unsigned N         = PE_N,
  parameter int unsigned SUM_WIDTH = PE_SUM_WIDTH,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 93
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bias_we,
  input  logic signed [N-1:0]         bias_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SUM_WIDTH-1:0] sum,
  input  logic signed [SUM_WIDTH-1:0] sum1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [N-1:0]         out_data,
  output logic                        out_last
);

  localparam int unsigned AW = pe_acc_width(SUM_WIDTH);
  localparam int unsigned RW = pe_rnd_width(SUM_WIDTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned FW = $clog2(FRAME_LEN + 1);

  localparam logic [RW-1:0] HALF    = RW'(1) << (SHIFT - 1);
  localparam logic [RW-1:0] SAT_MAX = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};

  logic signed [N-1:0]  bias_q, bias_d;
  logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic signed [AW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [RW-1:0]        s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [N-1:0]         s3_q, s3_d, sat_a, sat_b;
  logic [FW-1:0]        frame_q, frame_d;
  logic                 last_push, accept;
  logic [OW-1:0]        occupancy;

  logic [N:0]           fifo_rdata;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  function automatic logic [RW-1:0] relu_round(input logic signed [AW-1:0] x);
    logic [RW-1:0] pos;
    pos = x[AW-1] ? '0 : RW'(x);
    return (pos + HALF) >> SHIFT;
  endfunction

  function automatic logic [N-1:0] saturate(input logic [RW-1:0] v);
    return (v > SAT_MAX) ? SAT_MAX[N-1:0] : v[N-1:0];
  endfunction

  always_comb begin
    // Credits cover every beat that will land in the FIFO, so stage 3 never stalls.
    occupancy = OW'(fifo_count) + OW'(s1_v_q) + OW'(s2_v_q) + OW'(s3_v_q);
    in_ready  = rst || (occupancy < OW'(DEPTH));
    accept    = in_valid && in_ready && !rst;

    bias_d = bias_we ? bias_in : bias_q;

    s1_v_d = accept;
    s1_a_d = accept ? AW'(sum)  + AW'(bias_q) : s1_a_q;
    s1_b_d = accept ? AW'(sum1) + AW'(bias_q) : s1_b_q;

    s2_v_d = s1_v_q;
    s2_a_d = relu_round(s1_a_q);
    s2_b_d = relu_round(s1_b_q);

    s3_v_d = s2_v_q;
    sat_a  = saturate(s2_a_q);
    sat_b  = saturate(s2_b_q);
    s3_d   = (sat_a > sat_b) ? sat_a : sat_b;

    last_push = s3_v_q && (frame_q == FW'(FRAME_LEN - 1));
    frame_d   = frame_q;
    if (s3_v_q) begin
      frame_d = last_push ? '0 : frame_q + FW'(1);
    end

    out_valid = !fifo_empty && !rst;
    out_data  = rst ? '0 : fifo_rdata[N-1:0];
    out_last  = !rst && fifo_rdata[N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q  <= '0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      bias_q  <= bias_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s3_v_q  <= s3_v_d;
      frame_q <= frame_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_q <= s1_a_d;
    s1_b_q <= s1_b_d;
    s2_a_q <= s2_a_d;
    s2_b_q <= s2_b_d;
    s3_q   <= s3_d;
  end

  sync_fifo #(
    .WIDTH (N + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s3_v_q),
    .wdata ({last_push, s3_q}),
    .pop   (out_valid && out_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_pe_post_proc.sv
// Scoreboard bench for pe_post_proc: driver pushes model results, monitor pops on each output transfer.
module tb_pe_post_proc;

  localparam int unsigned N         = 16;
  localparam int unsigned SW        = 36;
  localparam int unsigned SHIFT     = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME_LEN = 3;

  logic                 clk = 1'b0;
  logic                 rst, bias_we, in_valid, in_ready;
  logic                 out_valid, out_ready, out_last;
  logic signed [N-1:0]  bias_in, out_data;
  logic signed [SW-1:0] sum, sum1;

  always #5 clk = ~clk;

  pe_post_proc #(
    .N         (N),
    .SUM_WIDTH (SW),
    .SHIFT     (SHIFT),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bias_we   (bias_we),
    .bias_in   (bias_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sum1      (sum1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t        sb[$];
  int          checks      = 0;
  int          failures    = 0;
  longint      model_bias  = 0;
  int unsigned model_count = 0;
  int          or_mode     = 2;   // 0 random, 1 stall, 2 always ready

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic longint lane(input longint s, input longint b);
    longint x;
    x = s + b;
    if (x < 0) x = 0;
    x = (x + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
    if (x > (longint'(1) << (N - 1)) - 1) x = (longint'(1) << (N - 1)) - 1;
    return x;
  endfunction

  task automatic expect_pair(input longint s, input longint s1);
    exp_t   e;
    longint a, b;
    a = lane(s, model_bias);
    b = lane(s1, model_bias);
    e.data = (a > b) ? a : b;
    model_count++;
    e.last = (model_count % FRAME_LEN) == 0;
    sb.push_back(e);
  endtask

  function automatic longint rnd_val();
    longint      r;
    int unsigned bits;
    r = longint'({$urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0:       bits = 13;
      1:       bits = 25;
      default: bits = SW;
    endcase
    return r >>> (64 - bits);
  endfunction

  // Entered in the low clock phase; returns at a falling edge.
  task automatic send_pair(input longint s, input longint s1, input bit we, input longint bv,
                           input int unsigned budget, output bit acc);
    bit rdy;
    acc      = 1'b0;
    sum      = s[SW-1:0];
    sum1     = s1[SW-1:0];
    bias_we  = we;
    bias_in  = bv[N-1:0];
    in_valid = 1'b1;
    for (int unsigned c = 0; c < budget && !acc; c++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        expect_pair(s, s1);
        acc = 1'b1;
      end
      if (bias_we) model_bias = bv;
      @(negedge clk);
      bias_we = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    bias_we  = 1'b0;
    sb.delete();
    model_bias  = 0;
    model_count = 0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    or_mode = 2;
    for (int unsigned c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_queue_empty", sb.size(), 0);
    #1 chk("drain_out_valid", out_valid, 0);
  endtask

  // Monitor: chooses out_ready, then checks every beat that will transfer on the next edge.
  initial begin : monitor
    exp_t                e;
    bit                  prev_stall = 1'b0;
    logic signed [N-1:0] prev_data  = '0;
    logic                prev_last  = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      #1;
      if (prev_stall && !rst) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, longint'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit     acc;
    longint bv;
    rst = 1'b1; bias_we = 1'b0; bias_in = '0; in_valid = 1'b0; sum = '0; sum1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Latency with an empty FIFO: visible after the third edge following acceptance.
    send_pair(1000, -500, 1'b0, 0, 10, acc);
    chk("lat_accept", acc, 1);
    #1 chk("lat_k0_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_k1_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_k2_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_k3_valid", out_valid, 1);
    chk("lat_k3_data", out_data, 4);
    drain();

    // ReLU and saturation corners.
    send_pair(-7, -90000, 1'b0, 0, 10, acc);
    chk("relu_accept", acc, 1);
    send_pair(longint'(1) << 30, 0, 1'b0, 0, 10, acc);
    chk("sat_accept", acc, 1);
    send_pair(-(longint'(1) << 35), (longint'(1) << 35) - 1, 1'b0, 0, 10, acc);
    chk("extreme_accept", acc, 1);
    drain();

    // Bias write: the pair accepted on the write edge still sees the old bias.
    send_pair(700, 0, 1'b1, -200, 10, acc);
    chk("bias_edge_accept", acc, 1);
    send_pair(328, 0, 1'b0, 0, 10, acc);
    chk("bias_new_accept", acc, 1);
    send_pair(700, 0, 1'b0, 0, 10, acc);
    chk("bias_new2_accept", acc, 1);
    drain();

    // Backpressure: credits run out after DEPTH accepts.
    or_mode = 1;
    for (int i = 0; i < 4; i++) begin
      send_pair(rnd_val(), rnd_val(), 1'b0, 0, 10, acc);
      chk("bp_accept", acc, 1);
    end
    send_pair(12345, 678, 1'b0, 0, 8, acc);
    chk("bp_blocked", acc, 0);
    #1 chk("bp_in_ready_low", in_ready, 0);
    or_mode = 2;
    send_pair(12345, 678, 1'b0, 0, 30, acc);
    chk("bp_resume5", acc, 1);
    send_pair(-4000, 99999, 1'b0, 0, 30, acc);
    chk("bp_resume6", acc, 1);
    drain();

    // Frame tagging from a fresh counter: last on outputs 3 and 6.
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      send_pair(rnd_val(), rnd_val(), 1'b0, 0, 10, acc);
      chk("frame_accept", acc, 1);
    end
    drain();

    // Reset with beats in flight: they must vanish and the frame count restarts.
    send_pair(5000, 1, 1'b0, 0, 10, acc);
    for (int i = 0; i < 3; i++) begin
      send_pair(rnd_val(), rnd_val(), 1'b0, 0, 10, acc);
    end
    do_reset(1);
    #1 chk("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1 chk("midrst_stale", out_valid, 0);
    end
    for (int i = 0; i < 3; i++) begin
      send_pair(rnd_val(), rnd_val(), 1'b0, 0, 10, acc);
      chk("midrst_after_accept", acc, 1);
    end
    drain();

    // Random traffic, random consumer, occasional bias writes.
    or_mode = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bv = longint'($signed(16'($urandom())));
      send_pair(rnd_val(), rnd_val(), ($urandom_range(0, 15) == 0), bv, 60, acc);
      chk("rand_accept", acc, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
